// File: rtl/pht_pkg.sv
// Shared definitions for the gshare PHT access controller: default widths,
// the queued update entry and the saturating counter step.
package pht_pkg;

    localparam int unsigned PHT_ADDR_W = 10;
    localparam int unsigned PHT_CNT_W  = 2;
    localparam int unsigned CNT_MAX    = (1 << PHT_CNT_W) - 1;

    typedef struct packed {
        logic [PHT_ADDR_W-1:0] idx;
        logic                  taken;
    } upd_entry_t;

    // Saturating step: never wraps past 0 or max.
    function automatic int unsigned sat_step(int unsigned cnt, int unsigned max, logic taken);
        if (taken) begin
            return (cnt >= max) ? max : cnt + 32'd1;
        end
        return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
    endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Synchronous FIFO holding resolved branch updates until the table port is free.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module pht_upd_fifo #(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    assign head  = mem_q[rd_ptr_q[PTR_W-2:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[PTR_W-2:0]] <= wdata;
        end
    end

endmodule

// File: rtl/pht_ctrl.sv
// gshare PHT port controller: arbitrates the single table port between fetch
// lookups and queued resolution updates, owns the GHR and the index hash.
module pht_ctrl #(
    parameter int unsigned ADDR_W     = pht_pkg::PHT_ADDR_W,
    parameter int unsigned CNT_W      = pht_pkg::PHT_CNT_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lk_valid,
    input  logic [31:0]       lk_pc,
    output logic              lk_ready,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_idx,
    input  logic              up_valid,
    input  logic [ADDR_W-1:0] up_idx,
    input  logic              up_taken,
    output logic              up_ready,
    output logic [ADDR_W-1:0] tab_addr,
    output logic              tab_wr_en,
    output logic [CNT_W-1:0]  tab_wr_data,
    input  logic [CNT_W-1:0]  tab_rd_data,
    output logic [ADDR_W-1:0] ghr,
    output logic              busy
);

    import pht_pkg::*;

    localparam int unsigned CntMax = (1 << CNT_W) - 1;

    logic [ADDR_W-1:0] ghr_q, ghr_d;
    logic              pred_valid_q, pred_valid_d;
    logic              pred_taken_q, pred_taken_d;
    logic [ADDR_W-1:0] pred_idx_q, pred_idx_d;

    logic [ADDR_W-1:0] lk_idx;
    logic              lk_grant, up_grant, push;
    logic              fifo_full, fifo_empty;
    logic [ADDR_W:0]   fifo_head;
    logic [ADDR_W-1:0] head_idx;
    logic              head_taken;
    logic              unused_pc;

    assign unused_pc  = ^{lk_pc[31:ADDR_W+2], lk_pc[1:0]};
    assign lk_idx     = lk_pc[ADDR_W+1:2] ^ ghr_q;
    assign head_idx   = fifo_head[ADDR_W:1];
    assign head_taken = fifo_head[0];

    // A full queue blocks lookups so updates cannot starve forever.
    assign lk_ready = !reset && !fifo_full;
    assign up_ready = !reset && !fifo_full;
    assign lk_grant = lk_valid && lk_ready;
    assign up_grant = !reset && !fifo_empty && !lk_grant;
    assign push     = up_valid && up_ready;

    pht_upd_fifo #(
        .DATA_W (ADDR_W + 1),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (up_grant),
        .wdata ({up_idx, up_taken}),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        tab_addr    = '0;
        tab_wr_en   = 1'b0;
        tab_wr_data = '0;
        if (lk_grant) begin
            tab_addr = lk_idx;
        end else if (up_grant) begin
            tab_addr    = head_idx;
            tab_wr_en   = 1'b1;
            tab_wr_data = CNT_W'(sat_step(32'(tab_rd_data), CntMax, head_taken));
        end
    end

    always_comb begin
        ghr_d        = ghr_q;
        pred_valid_d = lk_grant;
        pred_taken_d = pred_taken_q;
        pred_idx_d   = pred_idx_q;
        if (push) begin
            ghr_d = {ghr_q[ADDR_W-2:0], up_taken};
        end
        if (lk_grant) begin
            pred_taken_d = tab_rd_data[CNT_W-1];
            pred_idx_d   = lk_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
        end else begin
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_idx_q   <= pred_idx_d;
        end
    end

    assign ghr        = ghr_q;
    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_idx   = pred_idx_q;
    assign busy       = !fifo_empty;

endmodule

// File: tb/tb_pht_ctrl.sv
// Bench for pht_ctrl: a table model answers reads, a queue-based reference model
// is compared every cycle, and directed scenarios pin literal values.
module tb_pht_ctrl;

    import pht_pkg::*;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 2;
    localparam int DEPTH  = 4;
    localparam int TSIZE  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              lk_valid;
    logic [31:0]       lk_pc;
    logic              lk_ready;
    logic              pred_valid, pred_taken;
    logic [ADDR_W-1:0] pred_idx;
    logic              up_valid;
    logic [ADDR_W-1:0] up_idx;
    logic              up_taken;
    logic              up_ready;
    logic [ADDR_W-1:0] tab_addr;
    logic              tab_wr_en;
    logic [CNT_W-1:0]  tab_wr_data;
    logic [CNT_W-1:0]  tab_rd_data;
    logic [ADDR_W-1:0] ghr;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pht_ctrl #(
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lk_valid    (lk_valid),
        .lk_pc       (lk_pc),
        .lk_ready    (lk_ready),
        .pred_valid  (pred_valid),
        .pred_taken  (pred_taken),
        .pred_idx    (pred_idx),
        .up_valid    (up_valid),
        .up_idx      (up_idx),
        .up_taken    (up_taken),
        .up_ready    (up_ready),
        .tab_addr    (tab_addr),
        .tab_wr_en   (tab_wr_en),
        .tab_wr_data (tab_wr_data),
        .tab_rd_data (tab_rd_data),
        .ghr         (ghr),
        .busy        (busy)
    );

    // Table environment: combinational read, write on the edge, reset to weakly taken.
    logic [CNT_W-1:0] tab [TSIZE];
    assign tab_rd_data = tab[tab_addr];

    initial begin
        for (int i = 0; i < TSIZE; i++) tab[i] = 2'd2;
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TSIZE; i++) tab[i] <= 2'd2;
        end else if (tab_wr_en) begin
            tab[tab_addr] <= tab_wr_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(int v, bit t);
        if (t) return (v >= 3) ? 3 : v + 1;
        return (v <= 0) ? 0 : v - 1;
    endfunction

    // Reference model
    upd_entry_t m_q[$];
    int         tab_m [TSIZE];
    int         m_ghr = 0;
    bit         m_pv = 0, m_pt = 0;
    int         m_pi = 0;

    initial begin
        bit r, e_rdy, lk_g, up_g, psh, s_tk;
        int h_idx, e_addr, e_wd, s_idx, rd;
        for (int i = 0; i < TSIZE; i++) tab_m[i] = 2;
        @(posedge clk);
        forever begin
            @(negedge clk);
            r      = reset;
            e_rdy  = !r && (m_q.size() != DEPTH);
            lk_g   = lk_valid && e_rdy;
            up_g   = !r && (m_q.size() != 0) && !lk_g;
            psh    = up_valid && e_rdy;
            h_idx  = ((lk_pc >> 2) % TSIZE) ^ m_ghr;
            s_idx  = up_idx;
            s_tk   = up_taken;
            e_addr = lk_g ? h_idx : (up_g ? int'(m_q[0].idx) : 0);
            e_wd   = up_g ? sat(tab_m[m_q[0].idx], m_q[0].taken) : 0;
            rd     = lk_g ? tab_m[h_idx] : 0;
            chk("m_lk_ready", 32'(lk_ready), 32'(e_rdy));
            chk("m_up_ready", 32'(up_ready), 32'(e_rdy));
            chk("m_tab_addr", 32'(tab_addr), e_addr);
            chk("m_tab_wr_en", 32'(tab_wr_en), 32'(up_g));
            if (up_g) chk("m_tab_wr_data", 32'(tab_wr_data), e_wd);
            chk("m_ghr", 32'(ghr), m_ghr);
            chk("m_busy", 32'(busy), 32'(m_q.size() != 0));
            chk("m_pred_valid", 32'(pred_valid), 32'(m_pv));
            if (m_pv) begin
                chk("m_pred_taken", 32'(pred_taken), 32'(m_pt));
                chk("m_pred_idx", 32'(pred_idx), m_pi);
            end
            @(posedge clk);
            if (r) begin
                m_q.delete();
                m_ghr = 0;
                m_pv = 0;
                m_pt = 0;
                m_pi = 0;
                for (int i = 0; i < TSIZE; i++) tab_m[i] = 2;
            end else begin
                if (up_g) begin
                    tab_m[m_q[0].idx] = e_wd;
                    void'(m_q.pop_front());
                end
                if (psh) begin
                    m_q.push_back('{idx: s_idx[ADDR_W-1:0], taken: s_tk});
                    m_ghr = ((m_ghr << 1) | int'(s_tk)) % TSIZE;
                end
                m_pv = lk_g;
                if (lk_g) begin
                    m_pt = (rd >= 2);
                    m_pi = h_idx;
                end
            end
        end
    end

    // Write log for the saturation scenario
    bit log_en = 0;
    int wr_log[$];
    always @(negedge clk) begin
        if (log_en && tab_wr_en) wr_log.push_back(int'(tab_wr_data));
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        lk_valid = 1'b0;
        up_valid = 1'b0;
        adv();
        adv();
        reset = 1'b0;
    endtask

    initial begin
        int exp_w[7];
        exp_w = '{3, 3, 3, 2, 1, 0, 0};
        reset = 1'b1;
        lk_valid = 1'b1;
        lk_pc = 32'h10;
        up_valid = 1'b1;
        up_idx = 10'd3;
        up_taken = 1'b1;
        adv();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_lk_ready", 32'(lk_ready), 0);
            chk("rst_up_ready", 32'(up_ready), 0);
            chk("rst_pred_valid", 32'(pred_valid), 0);
            chk("rst_pred_taken", 32'(pred_taken), 0);
            chk("rst_pred_idx", 32'(pred_idx), 0);
            chk("rst_tab_wr_en", 32'(tab_wr_en), 0);
            chk("rst_tab_addr", 32'(tab_addr), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_ghr", 32'(ghr), 0);
            adv();
        end
        reset = 1'b0;
        lk_valid = 1'b0;
        up_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ghr", 32'(ghr), 0);
        adv();

        // Lookup at pc 0x10 with ghr 0 -> index 4
        lk_valid = 1'b1;
        lk_pc = 32'h10;
        @(negedge clk);
        chk("lk_tab_addr", 32'(tab_addr), 4);
        chk("lk_wr_en", 32'(tab_wr_en), 0);
        adv();
        lk_valid = 1'b0;
        @(negedge clk);
        chk("lk_pred_valid", 32'(pred_valid), 1);
        chk("lk_pred_idx", 32'(pred_idx), 4);
        chk("lk_pred_taken", 32'(pred_taken), 1);
        adv();
        @(negedge clk);
        chk("lk_pred_one_cycle", 32'(pred_valid), 0);
        adv();

        // Saturation on idx 4 starting from 2
        log_en = 1;
        for (int i = 0; i < 7; i++) begin
            up_valid = 1'b1;
            up_idx = 10'd4;
            up_taken = (i < 3);
            adv();
        end
        up_valid = 1'b0;
        adv();
        adv();
        log_en = 0;
        chk("sat_count", wr_log.size(), 7);
        for (int i = 0; i < 7; i++) begin
            chk("sat_write", (i < wr_log.size()) ? wr_log[i] : -1, exp_w[i]);
        end

        // Starvation guard under continuous lookups
        do_reset();
        lk_valid = 1'b1;
        lk_pc = 32'h10;
        for (int i = 0; i < 4; i++) begin
            up_valid = 1'b1;
            up_idx = ADDR_W'(10 + i);
            up_taken = (i % 2) == 1;
            @(negedge clk);
            chk("stv_lk_ready_fill", 32'(lk_ready), 1);
            adv();
        end
        up_valid = 1'b0;
        @(negedge clk);
        chk("stv_lk_ready_full", 32'(lk_ready), 0);
        chk("stv_up_ready_full", 32'(up_ready), 0);
        chk("stv_wr_en_full", 32'(tab_wr_en), 1);
        adv();
        @(negedge clk);
        chk("stv_lk_ready_after", 32'(lk_ready), 1);
        chk("stv_wr_en_after", 32'(tab_wr_en), 0);
        adv();
        lk_valid = 1'b0;
        repeat (4) adv();
        @(negedge clk);
        chk("stv_drained", 32'(busy), 0);
        adv();

        // GHR hash: taken, not-taken, taken -> 0b101
        do_reset();
        up_idx = 10'd7;
        for (int i = 0; i < 3; i++) begin
            up_valid = 1'b1;
            up_taken = (i != 1);
            adv();
        end
        up_valid = 1'b0;
        lk_valid = 1'b1;
        lk_pc = 32'h20;
        @(negedge clk);
        chk("ghr_value", 32'(ghr), 5);
        chk("ghr_hash", 32'(tab_addr), 13);
        adv();
        up_valid = 1'b1;
        up_taken = 1'b0;
        @(negedge clk);
        chk("ghr_hash_push_cycle", 32'(tab_addr), 13);
        adv();
        up_valid = 1'b0;
        lk_valid = 1'b0;
        @(negedge clk);
        chk("ghr_after_push", 32'(ghr), 10);
        adv();
        repeat (4) adv();

        // Reset mid-drain discards queued updates
        do_reset();
        lk_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_valid = 1'b1;
            up_idx = ADDR_W'(20 + i);
            up_taken = 1'b1;
            adv();
        end
        up_valid = 1'b0;
        lk_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_busy_before", 32'(busy), 1);
        chk("mid_wr_en_in_reset", 32'(tab_wr_en), 0);
        adv();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_wr_en_after", 32'(tab_wr_en), 0);
            chk("mid_busy_after", 32'(busy), 0);
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
